uart_cmd_ctrl: RTL
==================

// Module: uart_cmd_ctrl
// PURPOSE
//  Sequences the byte stream from uart_rx into register commands. Detects each new rx byte,
//  parses a fixed frame SYNC/CMD/ADDR/DATA[/CHK], and issues one valid/ready write or read
//  request to the downstream register block. Handles frame errors, inter-byte timeout and
//  overrun while a command is pending.
// PARAMETERS
//  SYNC_BYTE  8'hA5   frame start marker
//  ADDR_W     4       cmd_addr width; ADDR byte bits above ADDR_W-1 must be 0, else error
//  TIMEOUT    50000   max clk cycles between bytes of one frame (>=2); counter 16 bits
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-low reset
//  rx_dout       in   8       byte from uart_rx, stable while rx_done_tick high
//  rx_done_tick  in   1       uart_rx done level (s_tick domain, asynchronous to clk)
//  cmd_valid     out  1       command pending; held until cmd_ready
//  cmd_ready     in   1       downstream accepts command when cmd_valid & cmd_ready
//  cmd_write     out  1       1 = write ('W' 8'h57), 0 = read ('R' 8'h52)
//  cmd_addr      out  ADDR_W  register address
//  cmd_data      out  8       write data (DATA byte; still carried for reads)
//  err_pulse     out  1       one-cycle pulse on any frame error
//  err_code      out  2       last error: 0 none,1 bad cmd/addr,2 checksum,3 timeout
//  err_count     out  8       saturating error count (stops at 8'hFF)
//  overrun       out  1       sticky; byte arrived while cmd_valid high
// BEHAVIOUR
//  Reset (reset==0 at posedge clk): state=IDLE; all outputs 0; sync flops preset to 1
//   (uart_rx idles with rx_done_tick=1) so no spurious byte after reset.
//  Byte detect: rx_done_tick -> 2-flop sync -> edge reg; byte_evt on sync 0->1; rx_dout
//   captured same cycle. byte_evt occurs 3 clk after the rx_done_tick rise.
//  States: IDLE, CMD, ADDR, DATA, CHK, ISSUE.
//   IDLE : byte_evt & byte==SYNC_BYTE -> CMD; other bytes ignored silently.
//   CMD  : byte 8'h57/8'h52 -> ADDR (latch cmd_write); else error 1 -> IDLE.
//   ADDR : high bits zero -> DATA (latch addr); else error 1 -> IDLE.
//   DATA : latch data -> CHK (or ISSUE, see CONFIGURATION).
//   CHK  : byte == CMD^ADDR^DATA -> ISSUE; else error 2 -> IDLE.
//   ISSUE: cmd_valid=1, outputs stable; on cmd_valid&cmd_ready -> IDLE, cmd_valid=0 next cycle.
//  cmd_valid rises the cycle after the last frame byte's byte_evt.
//  Timeout: counter cleared on every byte_evt and in IDLE/ISSUE; in CMD..CHK, reaching
//   TIMEOUT -> error 3 -> IDLE. Not counted in ISSUE (downstream stall is legal).
//  Overrun: byte_evt in ISSUE: byte dropped, overrun set until reset; no error pulse.
//  Error: err_pulse 1 cycle, err_code updated, err_count+1 (saturate). Error and new
//   byte never coincide (single byte_evt per cycle).
//  Same-cycle accept & byte_evt in ISSUE: command accepted, byte dropped, overrun set.
//  Reset mid-frame or during ISSUE: abandoned; no command issued after reset.
// CONFIGURATION
//  UART_CMD_CHECKSUM_EN defined: 5-byte frame, CHK state active, error code 2 possible.
//  Undefined: 4-byte frame; DATA -> ISSUE directly; CHK logic absent; err_code never 2.
// TESTING
//  1 Reset: hold reset=0 3 clk with rx_done_tick=1 -> all outputs 0, no cmd_valid.
//  2 Bytes A5,57,03,3C,68 (CHK on) -> cmd_valid, cmd_write=1, addr=3, data=3C; cmd_ready
//    held 0 for 10 clk -> outputs stable; ready=1 -> cmd_valid low next cycle.
//  3 A5,52,03,00,51 -> read, addr=3; then A5,57,03,3C,00 -> err_code=2, err_pulse, count=1.
//  4 A5,41 -> err_code=1; A5,57,13 (ADDR_W=4) -> err_code=1, count=2, no cmd_valid.
//  5 A5,57 then idle TIMEOUT+5 clk -> err_code=3; next valid frame accepted normally.
//  6 Valid frame, cmd_ready=0, send extra byte 55 -> overrun=1, cmd fields unchanged.

Source files
------------

// File: rtl/uart_cmd_ctrl_if.sv
// Command bus between the UART frame parser and the downstream register block.
// Ports: cmd_valid/cmd_ready handshake, cmd_write (1=write), cmd_addr, cmd_data.
// master = command issuer (uart_cmd_ctrl), slave = register block.
interface uart_cmd_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/DATA[/CHK] byte frames from uart_rx and issues one
// valid/ready register command per frame; errors, timeout and overrun reported.
// Latency: cmd_valid rises the cycle after the last frame byte is detected;
// the command is held until cmd_ready, and bytes arriving meanwhile are dropped.
// Ports: clk, reset (sync, active-low), rx_dout/rx_done_tick (from uart_rx),
//   cmd (uart_cmd_ctrl_if.master), err_pulse, err_code, err_count, overrun.
// Optional: define UART_CMD_CHECKSUM_EN for the 5-byte frame with XOR checksum.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         ADDR_W    = 4,
  parameter int         TIMEOUT   = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_dout,
  input  logic             rx_done_tick,
  uart_cmd_ctrl_if.master  cmd,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [7:0]       err_count,
  output logic             overrun
);

  localparam logic [7:0]  CMD_WR  = 8'h57;
  localparam logic [7:0]  CMD_RD  = 8'h52;
  localparam logic [15:0] TMO_END = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    CHK   = 3'd4,
    ISSUE = 3'd5
  } state_t;

  state_t state, state_nxt;

  // rx_done_tick crosses from the uart_rx tick domain. Flops preset to 1 because
  // uart_rx idles with the done level high; a 0 preset would fake a byte.
  logic sync1, sync2, sync_prev;
  logic byte_evt;

  logic [15:0]       tmo_cnt;
  logic              tmo_hit;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;

  logic       ld_cmd, ld_addr, ld_data, ovr_set, err_now;
  logic [1:0] err_sel;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] chk_acc;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= rx_done_tick;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign byte_evt = sync2 & ~sync_prev;

  // Inter-byte timer: only runs while a frame is partially received.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || state == ISSUE || byte_evt) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != 16'hFFFF) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = (state != IDLE) && (state != ISSUE) && !byte_evt &&
                   (tmo_cnt >= TMO_END);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_cmd    = 1'b0;
    ld_addr   = 1'b0;
    ld_data   = 1'b0;
    ovr_set   = 1'b0;
    err_now   = 1'b0;
    err_sel   = 2'd0;
    case (state)
      IDLE: begin
        if (byte_evt && rx_dout == SYNC_BYTE) state_nxt = CMD;
      end
      CMD: begin
        if (byte_evt) begin
          if (rx_dout == CMD_WR || rx_dout == CMD_RD) begin
            ld_cmd    = 1'b1;
            state_nxt = ADDR;
          end else begin
            err_now   = 1'b1;
            err_sel   = 2'd1;
            state_nxt = IDLE;
          end
        end
      end
      ADDR: begin
        if (byte_evt) begin
          if ((rx_dout >> ADDR_W) == 8'd0) begin
            ld_addr   = 1'b1;
            state_nxt = DATA;
          end else begin
            err_now   = 1'b1;
            err_sel   = 2'd1;
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (byte_evt) begin
          ld_data = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = ISSUE;
`endif
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      CHK: begin
        if (byte_evt) begin
          if (rx_dout == chk_acc) begin
            state_nxt = ISSUE;
          end else begin
            err_now   = 1'b1;
            err_sel   = 2'd2;
            state_nxt = IDLE;
          end
        end
      end
`endif
      ISSUE: begin
        // A byte here is lost even if the command is accepted this same cycle.
        if (byte_evt) ovr_set = 1'b1;
        if (cmd.cmd_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // tmo_hit excludes byte_evt cycles, so it never overrides a byte decision.
    if (tmo_hit) begin
      err_now   = 1'b1;
      err_sel   = 2'd3;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (ld_cmd)  write_q <= (rx_dout == CMD_WR);
      if (ld_addr) addr_q  <= rx_dout[ADDR_W-1:0];
      if (ld_data) data_q  <= rx_dout;
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  // Running XOR of CMD, ADDR and DATA bytes; the CHK byte must equal it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_acc <= '0;
    end else if (ld_cmd) begin
      chk_acc <= rx_dout;
    end else if (ld_addr || ld_data) begin
      chk_acc <= chk_acc ^ rx_dout;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_pulse <= 1'b0;
      err_code  <= 2'd0;
      err_count <= 8'd0;
      overrun   <= 1'b0;
    end else begin
      err_pulse <= err_now;
      if (err_now) err_code <= err_sel;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (ovr_set) overrun <= 1'b1;
    end
  end

  assign cmd.cmd_valid = (state == ISSUE);
  assign cmd.cmd_write = write_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_data  = data_q;

endmodule
